// File: rtl/udma_uart_pkg.sv
// Shared UART types and helpers, used by the TX serializer and the RX engine.
package udma_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // 00=5 .. 11=8 data bits; four bits wide because 8 does not fit in three.
  function automatic logic [3:0] num_data_bits(input logic [1:0] bits);
    return 4'd5 + {2'b00, bits};
  endfunction

endpackage

// File: rtl/udma_uart_baud_cnt.sv
// Bit-period counter: counts up from 0 and flags the last cycle of a bit period.
module udma_uart_baud_cnt (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clr_i,
  input  logic [15:0] div_i,
  output logic        tick_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign tick_o = (cnt_q == div_i);

endmodule

// File: rtl/udma_uart_tx_serializer.sv
// UART transmit engine: start bit, 5..8 data bits LSB first, optional even parity,
// 1 or 2 stop bits, with the line config frozen per frame at the byte handshake.
module udma_uart_tx_serializer
  import udma_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic [15:0]           cfg_div_i,
  input  logic [1:0]            cfg_bits_i,
  input  logic                  cfg_parity_en_i,
  input  logic                  cfg_stop_bits_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  tx_state_e             state_q;
  logic                  tx_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [15:0]           div_q;
  logic [3:0]            nbits_q;
  logic                  par_en_q;
  logic                  stop2_q;
  logic                  par_q;
  logic [3:0]            bit_idx_q;

  logic                  tick;
  logic                  accept;
  logic                  par_next;
  logic [3:0]            nbits_next;

  // Held in reset so the ready output is low for the whole reset window.
  assign tx_ready_o = (state_q == StIdle) & cfg_en_i & rstn_i;
  assign accept     = tx_valid_i & tx_ready_o;
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;

  // Even parity over the bits that will actually be sent.
  always_comb begin
    par_next   = 1'b0;
    nbits_next = num_data_bits(cfg_bits_i);
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (i < int'(nbits_next)) par_next = par_next ^ tx_data_i[i];
    end
  end

  udma_uart_baud_cnt u_baud_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  ((state_q == StIdle) | tick),
    .div_i  (div_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      div_q     <= '0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_q     <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q   <= StStart;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            shift_q   <= tx_data_i;
            div_q     <= cfg_div_i;
            nbits_q   <= nbits_next;
            par_en_q  <= cfg_parity_en_i;
            stop2_q   <= cfg_stop_bits_i;
            par_q     <= par_next;
            bit_idx_q <= '0;
          end
        end
        StStart: begin
          if (tick) begin
            state_q   <= StData;
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
          end
        end
        StData: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == nbits_q - 4'd1) begin
              bit_idx_q <= '0;
              if (par_en_q) begin
                state_q <= StParity;
                tx_q    <= par_q;
              end else begin
                state_q <= StStop;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
              tx_q      <= shift_q[1];
            end
          end
        end
        StParity: begin
          if (tick) begin
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
        end
        StStop: begin
          if (tick) begin
            // bit_idx_q counts stop bits here.
            if (stop2_q && (bit_idx_q == 4'd0)) begin
              bit_idx_q <= 4'd1;
            end else begin
              state_q   <= StIdle;
              busy_q    <= 1'b0;
              bit_idx_q <= '0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udma_uart_tx_serializer.sv
// Self-checking bench: randomized and directed frames checked cycle by cycle against
// a waveform built from the frame format rules.
module tb_udma_uart_tx_serializer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_en = 1'b1;
  logic [15:0] cfg_div = 16'd0;
  logic [1:0]  cfg_bits = 2'b11;
  logic        cfg_par = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx_line;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  udma_uart_tx_serializer #(.DATA_WIDTH(8)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .cfg_en_i        (cfg_en),
    .cfg_div_i       (cfg_div),
    .cfg_bits_i      (cfg_bits),
    .cfg_parity_en_i (cfg_par),
    .cfg_stop_bits_i (cfg_stop),
    .tx_data_i       (tx_data),
    .tx_valid_i      (tx_valid),
    .tx_ready_o      (tx_ready),
    .tx_o            (tx_line),
    .busy_o          (busy)
  );

  // Expected line level for every clock of one frame.
  function automatic void build_frame(input logic [7:0] d, input logic [1:0] b, input logic p,
                                      input logic s, input logic [15:0] dv);
    logic bits_q[$];
    int   n;
    logic par;
    n   = int'(b) + 5;
    par = 1'b0;
    bits_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits_q.push_back(d[i]);
      par ^= d[i];
    end
    if (p) bits_q.push_back(par);
    bits_q.push_back(1'b1);
    if (s) bits_q.push_back(1'b1);
    exp_q.delete();
    foreach (bits_q[k]) for (int c = 0; c <= int'(dv); c++) exp_q.push_back(bits_q[k]);
  endfunction

  task automatic drive_frame(input logic [7:0] d, input logic [1:0] b, input logic p,
                             input logic s, input logic [15:0] dv);
    @(negedge clk);
    tx_data  = d;
    cfg_bits = b;
    cfg_par  = p;
    cfg_stop = s;
    cfg_div  = dv;
    tx_valid = 1'b1;
    build_frame(d, b, p, s, dv);
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (tx_line !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset cyc=%0d tx/busy/rdy=%b%b%b want 100", c, tx_line, busy, tx_ready);
      end
    end
    tx_valid = 1'b0;
    rstn     = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx_line !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release tx/busy/rdy=%b%b%b want 101", tx_line, busy, tx_ready);
    end
  endtask

  task automatic test_frame_formats();
    logic [7:0]  d;
    logic [1:0]  b;
    logic        p, s;
    logic [15:0] dv;
    for (int k = 0; k < 12; k++) begin
      case (k)
        0:       begin d = 8'hA5; b = 2'b11; p = 1'b0; s = 1'b0; dv = 16'd3; end
        1:       begin d = 8'hFF; b = 2'b10; p = 1'b1; s = 1'b1; dv = 16'd0; end
        2:       begin d = 8'h13; b = 2'b00; p = 1'b1; s = 1'b1; dv = 16'd1; end
        default: begin
          d  = 8'($urandom);
          b  = 2'($urandom);
          p  = 1'($urandom);
          s  = 1'($urandom);
          dv = 16'($urandom_range(0, 5));
        end
      endcase
      drive_frame(d, b, p, s, dv);
      vectors++;
      if (tx_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL fmt%0d_ready rdy=%b want 1", k, tx_ready);
      end
      for (int c = 0; c < exp_q.size(); c++) begin
        @(negedge clk);
        if (c == 0) tx_valid = 1'b0;
        vectors++;
        if (tx_line !== exp_q[c] || busy !== 1'b1 || tx_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL fmt%0d cyc=%0d tx/busy/rdy=%b%b%b want %b10", k, c, tx_line, busy,
                   tx_ready, exp_q[c]);
        end
      end
      @(negedge clk);
      vectors++;
      if (tx_line !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL fmt%0d_idle tx/busy/rdy=%b%b%b want 101", k, tx_line, busy, tx_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive_frame(8'h01, 2'b11, 1'b0, 1'b0, 16'd0);
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      if (c == 0) tx_data = 8'h02;
      vectors++;
      if (tx_line !== exp_q[c] || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_f1 cyc=%0d tx/busy=%b%b want %b1", c, tx_line, busy, exp_q[c]);
      end
    end
    @(negedge clk);
    vectors++;
    if (tx_line !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_gap tx/busy/rdy=%b%b%b want 101", tx_line, busy, tx_ready);
    end
    build_frame(8'h02, 2'b11, 1'b0, 1'b0, 16'd0);
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      if (c == 0) tx_valid = 1'b0;
      vectors++;
      if (tx_line !== exp_q[c] || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_f2 cyc=%0d tx/busy=%b%b want %b1", c, tx_line, busy, exp_q[c]);
      end
    end
    @(negedge clk);
    vectors++;
    if (tx_line !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end tx/busy=%b%b want 10", tx_line, busy);
    end
  endtask

  task automatic test_cfg_change();
    logic [7:0] d2;
    d2 = 8'($urandom);
    drive_frame(8'($urandom), 2'b11, 1'b0, 1'b0, 16'd3);
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      if (c == 0) tx_valid = 1'b0;
      if (c == 6) begin
        cfg_div  = 16'd7;
        cfg_bits = 2'b00;
      end
      vectors++;
      if (tx_line !== exp_q[c] || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL cfg_f1 cyc=%0d tx/busy=%b%b want %b1", c, tx_line, busy, exp_q[c]);
      end
    end
    drive_frame(d2, 2'b00, 1'b0, 1'b0, 16'd7);
    for (int c = 0; c < exp_q.size() + 1; c++) begin
      @(negedge clk);
      if (c == 0) tx_valid = 1'b0;
      vectors++;
      if (c == exp_q.size()) begin
        if (tx_line !== 1'b1 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL cfg_f2_end tx/busy=%b%b want 10", tx_line, busy);
        end
      end else if (tx_line !== exp_q[c] || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL cfg_f2 cyc=%0d tx/busy=%b%b want %b1", c, tx_line, busy, exp_q[c]);
      end
    end
  endtask

  task automatic test_en_drop();
    drive_frame(8'($urandom), 2'b11, 1'b1, 1'b0, 16'd1);
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      if (c == 0) tx_valid = 1'b0;
      if (c == 4) cfg_en = 1'b0;
      if (c == 6) tx_valid = 1'b1;
      vectors++;
      if (tx_line !== exp_q[c] || busy !== 1'b1 || tx_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL en_drop cyc=%0d tx/busy/rdy=%b%b%b want %b10", c, tx_line, busy,
                 tx_ready, exp_q[c]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (tx_line !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL en_drop_idle cyc=%0d tx/busy/rdy=%b%b%b want 100", c, tx_line, busy,
                 tx_ready);
      end
    end
    tx_valid = 1'b0;
    cfg_en   = 1'b1;
  endtask

  task automatic test_reset_mid();
    drive_frame(8'h00, 2'b11, 1'b0, 1'b0, 16'd2);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) tx_valid = 1'b0;
      vectors++;
      if (tx_line !== exp_q[c] || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_mid cyc=%0d tx/busy=%b%b want %b1", c, tx_line, busy, exp_q[c]);
      end
    end
    rstn = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx_line !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_abort tx/busy/rdy=%b%b%b want 100", tx_line, busy, tx_ready);
    end
    rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx_line !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_release tx/busy/rdy=%b%b%b want 101", tx_line, busy, tx_ready);
    end
  endtask

  initial begin
    test_reset();
    test_frame_formats();
    test_back_to_back();
    test_cfg_change();
    test_en_drop();
    test_reset_mid();
    test_frame_formats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
